// File: rtl/fetch_issue_ctrl.sv
// Fetch/issue sequencer: requests bus bursts, splits 64-bit beats into two
// instructions, queues them and issues one per cycle to decode.
module fetch_issue_ctrl #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BURST_BEATS    = 8,
  parameter int QUEUE_DEPTH    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      fetch_req,
  input  logic                      fetch_gnt,
  input  logic                      data_valid,
  input  logic [BUS_DATA_WIDTH-1:0] data,
  input  logic                      data_last,
  output logic                      issue_valid,
  output logic [31:0]               issue_ins,
  input  logic                      issue_ready,
  input  logic                      wb_stall,
  output logic                      halt,
  output logic                      busy,
  output logic                      overflow,
  output logic [31:0]               ins_count
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_REQ   = 3'd2;
  localparam logic [2:0] S_BURST = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [31:0]   r_mem [QUEUE_DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW-1:0] w_tail1;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_free;
  logic          r_fetch_req;
  logic          r_halt_pend;
  logic          r_overflow;
  logic [31:0]   r_ins_count;

  logic          w_nonempty;
  logic [31:0]   w_head_ins;
  logic          w_head_zero;
  logic          w_issue_valid;
  logic          w_pop;
  logic          w_beat;
  logic          w_discard;
  logic          w_room;
  logic          w_push;
  logic          w_ovf;
  logic          w_flush;

  assign w_tail1     = r_tail + PW'(1);
  assign w_free      = CW'(QUEUE_DEPTH) - r_count;
  assign w_nonempty  = (r_count != '0);
  assign w_head_ins  = r_mem[r_head];
  assign w_head_zero = w_nonempty && (w_head_ins == '0);

  assign w_issue_valid = w_nonempty && !wb_stall && (r_state != S_HALT) &&
                         !w_head_zero && !r_halt_pend;
  assign w_pop         = w_issue_valid && issue_ready;

  // Once a zero instruction sits at the head mid-burst, remaining beats are
  // drained from the bus but never stored.
  assign w_beat    = (r_state == S_BURST) && data_valid;
  assign w_discard = r_halt_pend || w_head_zero;
  assign w_room    = (w_free >= CW'(2));
  assign w_push    = w_beat && !w_discard && w_room;
  assign w_ovf     = w_beat && !w_discard && !w_room;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_WAIT;
      S_WAIT:  if (w_free >= CW'(2 * BURST_BEATS)) w_next = S_REQ;
      S_REQ:   if (fetch_gnt) w_next = S_BURST;
      S_BURST: if (data_valid && data_last) w_next = w_discard ? S_HALT : S_WAIT;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
    // Outside a burst a zero head halts at once, abandoning any pending request.
    if (w_head_zero && (r_state != S_BURST) && (r_state != S_HALT))
      w_next = S_HALT;
  end

  assign w_flush = (w_next == S_HALT) && (r_state != S_HALT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_fetch_req <= 1'b0;
      r_halt_pend <= 1'b0;
      r_overflow  <= 1'b0;
      r_ins_count <= '0;
    end else begin
      r_state     <= w_next;
      r_fetch_req <= (w_next == S_REQ);
      r_overflow  <= r_overflow | w_ovf;
      if ((r_state == S_BURST) && (w_next == S_BURST))
        r_halt_pend <= r_halt_pend | w_head_zero;
      else
        r_halt_pend <= 1'b0;
      if (w_pop)
        r_ins_count <= r_ins_count + 32'd1;
      if (w_flush) begin
        r_count <= '0;
        r_head  <= r_tail;
      end else begin
        r_count <= r_count + (w_push ? CW'(2) : CW'(0)) - (w_pop ? CW'(1) : CW'(0));
        if (w_pop)
          r_head <= r_head + PW'(1);
        if (w_push)
          r_tail <= r_tail + PW'(2);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail]  <= data[31:0];
      r_mem[w_tail1] <= data[63:32];
    end
  end

  assign fetch_req   = r_fetch_req;
  assign issue_valid = w_issue_valid;
  assign issue_ins   = w_nonempty ? w_head_ins : '0;
  assign halt        = (r_state == S_HALT);
  assign busy        = (r_state != S_IDLE) && (r_state != S_HALT);
  assign overflow    = r_overflow;
  assign ins_count   = r_ins_count;

endmodule

// File: tb/tb_fetch_issue_ctrl.sv
// Directed bench for fetch_issue_ctrl with an instruction scoreboard.
module tb_fetch_issue_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        fetch_req;
  logic        fetch_gnt;
  logic        data_valid;
  logic [63:0] data;
  logic        data_last;
  logic        issue_valid;
  logic [31:0] issue_ins;
  logic        issue_ready;
  logic        wb_stall;
  logic        halt;
  logic        busy;
  logic        overflow;
  logic [31:0] ins_count;

  int          total;
  int          bad;
  logic [31:0] sb [$];
  logic        hold_v;
  logic [31:0] hold_ins;

  fetch_issue_ctrl #(
    .BUS_DATA_WIDTH(64),
    .BURST_BEATS   (8),
    .QUEUE_DEPTH   (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .fetch_req  (fetch_req),
    .fetch_gnt  (fetch_gnt),
    .data_valid (data_valid),
    .data       (data),
    .data_last  (data_last),
    .issue_valid(issue_valid),
    .issue_ins  (issue_ins),
    .issue_ready(issue_ready),
    .wb_stall   (wb_stall),
    .halt       (halt),
    .busy       (busy),
    .overflow   (overflow),
    .ins_count  (ins_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sampled at the falling edge: handshake scoreboard, stall and hold rules.
  task automatic mon();
    logic [31:0] e;
    if (wb_stall)
      chk("stall_valid", {31'd0, issue_valid}, 32'd0);
    if (hold_v && !wb_stall) begin
      chk("hold_valid", {31'd0, issue_valid}, 32'd1);
      chk("hold_ins", issue_ins, hold_ins);
    end
    if (issue_valid && issue_ready) begin
      if (sb.size() == 0)
        chk("sb_unexpected_issue", 32'd0, 32'd1);
      else begin
        e = sb.pop_front();
        chk("issue_ins", issue_ins, e);
      end
    end
    hold_v   = issue_valid && !issue_ready;
    hold_ins = issue_ins;
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_fetch_req"}, {31'd0, fetch_req}, 32'd0);
    chk({tag, "_issue_valid"}, {31'd0, issue_valid}, 32'd0);
    chk({tag, "_issue_ins"}, issue_ins, 32'd0);
    chk({tag, "_halt"}, {31'd0, halt}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
    chk({tag, "_ins_count"}, ins_count, 32'd0);
  endtask

  task automatic wait_req(input bit toggle);
    int n;
    n = 0;
    while (!fetch_req && n < 100) begin
      if (toggle) issue_ready = ~issue_ready;
      step();
      n++;
    end
    chk("req_wait", {31'd0, fetch_req}, 32'd1);
    issue_ready = 1'b1;
  endtask

  task automatic grant();
    fetch_gnt = 1'b1;
    step();
    fetch_gnt = 1'b0;
    chk("req_drop", {31'd0, fetch_req}, 32'd0);
  endtask

  task automatic send_beat(input logic [31:0] lo, input logic [31:0] hi,
                           input bit last, input bit push);
    data       = {hi, lo};
    data_valid = 1'b1;
    data_last  = last;
    if (push) begin
      sb.push_back(lo);
      sb.push_back(hi);
    end
    step();
    data_valid = 1'b0;
    data_last  = 1'b0;
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    sb.delete();
    hold_v = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] base;
    total = 0; bad = 0; hold_v = 1'b0; hold_ins = '0;
    reset = 1'b0; start = 1'b0; fetch_gnt = 1'b0; data_valid = 1'b0;
    data = '0; data_last = 1'b0; issue_ready = 1'b1; wb_stall = 1'b0;

    // Reset state and basic burst with issue_ready held high
    step();
    step();
    chk_zero("rst");
    reset = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    wait_req(1'b0);
    grant();
    base = 32'h0000_1000;
    for (int i = 0; i < 8; i++)
      send_beat(base + 32'(2 * i), base + 32'(2 * i + 1), i == 7, 1'b1);
    wait_req(1'b0);
    chk("t1_drained", 32'(sb.size()), 32'd0);
    chk("t1_count", ins_count, 32'd16);

    // issue_ready toggling: head held across each not-ready cycle
    grant();
    base = 32'h0000_2000;
    for (int i = 0; i < 8; i++) begin
      issue_ready = i[0];
      send_beat(base + 32'(2 * i), base + 32'(2 * i + 1), i == 7, 1'b1);
    end
    wait_req(1'b1);
    chk("t2_drained", 32'(sb.size()), 32'd0);
    chk("t2_count", ins_count, 32'd32);

    // wb_stall over five cycles mid-issue
    grant();
    base = 32'h0000_3000;
    for (int i = 0; i < 8; i++) begin
      wb_stall = (i >= 2) && (i < 7);
      send_beat(base + 32'(2 * i), base + 32'(2 * i + 1), i == 7, 1'b1);
    end
    wb_stall = 1'b0;
    wait_req(1'b0);
    chk("t3_drained", 32'(sb.size()), 32'd0);
    chk("t3_count", ins_count, 32'd48);

    // Zero instruction in beat 3 low half: six issued, then halt after data_last
    grant();
    base = 32'h0000_4000;
    for (int i = 0; i < 8; i++)
      send_beat((i == 3) ? 32'd0 : base + 32'(2 * i), base + 32'(2 * i + 1), i == 7, i < 3);
    for (int i = 0; i < 3; i++) step();
    chk("t4_halt", {31'd0, halt}, 32'd1);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_req", {31'd0, fetch_req}, 32'd0);
    chk("t4_valid", {31'd0, issue_valid}, 32'd0);
    chk("t4_count", ins_count, 32'd54);
    chk("t4_drained", 32'(sb.size()), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("t4_halt_sticky", {31'd0, halt}, 32'd1);
    chk("t4_start_ignored", {31'd0, busy}, 32'd0);
    chk("t4_req_after_start", {31'd0, fetch_req}, 32'd0);

    // Beats outside BURST ignored; ninth beat into a full queue overflows
    do_reset();
    chk_zero("t5_rst");
    send_beat(32'h0000_5555, 32'h0000_6666, 1'b1, 1'b0);
    send_beat(32'h0000_5555, 32'h0000_6666, 1'b0, 1'b0);
    chk("t5_idle_valid", {31'd0, issue_valid}, 32'd0);
    chk("t5_idle_busy", {31'd0, busy}, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    data_valid = 1'b1;
    data = {32'h0000_7777, 32'h0000_8888};
    wait_req(1'b0);
    data_valid = 1'b0;
    chk("t5_wait_valid", {31'd0, issue_valid}, 32'd0);
    issue_ready = 1'b0;
    grant();
    base = 32'h0000_5000;
    for (int i = 0; i < 8; i++)
      send_beat(base + 32'(2 * i), base + 32'(2 * i + 1), 1'b0, 1'b1);
    chk("t5_no_ovf_full", {31'd0, overflow}, 32'd0);
    send_beat(32'h0000_9999, 32'h0000_aaaa, 1'b1, 1'b0);
    chk("t5_overflow", {31'd0, overflow}, 32'd1);
    issue_ready = 1'b1;
    wait_req(1'b0);
    chk("t5_drained", 32'(sb.size()), 32'd0);
    chk("t5_count", ins_count, 32'd16);
    chk("t5_ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset asserted in the middle of beat 4
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_req(1'b0);
    grant();
    base = 32'h0000_6000;
    for (int i = 0; i < 4; i++)
      send_beat(base + 32'(2 * i), base + 32'(2 * i + 1), 1'b0, 1'b1);
    data       = {base + 32'd9, base + 32'd8};
    data_valid = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    sb.delete();
    hold_v = 1'b0;
    chk_zero("t6_async");
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 5; i < 8; i++)
      send_beat(base + 32'(2 * i), base + 32'(2 * i + 1), i == 7, 1'b0);
    step();
    chk("t6_valid", {31'd0, issue_valid}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_req", {31'd0, fetch_req}, 32'd0);
    chk("t6_count", ins_count, 32'd0);
    chk("t6_ins", issue_ins, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
